// File: rtl/spi_link_pkg.sv
// Shared SPI link definitions: opcodes, header layout and the command/state enums
// used by both the host-side encoder and the link receiver.
package spi_link_pkg;

    localparam logic [7:0] OPC_WRITE_8BIT_REG = 8'h87;
    localparam logic [7:0] OPC_RX_DATA        = 8'h88;
    localparam logic [7:0] OPC_RX_SD_DATA     = 8'h89;
    localparam logic [7:0] OPC_READ_SD_FIFO   = 8'h8A;

    localparam int HEADER_SIZE  = 2;
    localparam int SD_WRITE_BIT = 7;

    typedef enum logic [2:0] {
        OP_DAC_WR  = 3'd0,
        OP_STREAM  = 3'd1,
        OP_SD_WR   = 3'd2,
        OP_SD_RD   = 3'd3,
        OP_FIFO_RD = 3'd4
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_ARG0,
        ST_ARG1,
        ST_BODY
    } tx_state_t;

    function automatic logic op_known(cmd_op_t op);
        return op inside {OP_DAC_WR, OP_STREAM, OP_SD_WR, OP_SD_RD, OP_FIFO_RD};
    endfunction

    function automatic logic [7:0] op_opcode(cmd_op_t op);
        case (op)
            OP_DAC_WR:          return OPC_WRITE_8BIT_REG;
            OP_STREAM:          return OPC_RX_DATA;
            OP_SD_WR, OP_SD_RD: return OPC_RX_SD_DATA;
            OP_FIFO_RD:         return OPC_READ_SD_FIFO;
            default:            return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/spi_link_cmd_tx.sv
// Host-side SPI link command encoder: serialises one latched command into opcode/arg/body
// bytes, one byte in flight at a time, and returns the byte clocked back on the dummy slot.
module spi_link_cmd_tx
    import spi_link_pkg::*;
#(
    parameter logic [7:0] DUMMY_BYTE = 8'h00,
    parameter int         LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [6:0]       cmd_addr,
    input  logic [7:0]       cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             body_valid,
    input  logic [7:0]       body_data,
    output logic             body_ready,
    output logic             tx_valid,
    output logic [7:0]       tx_byte,
    input  logic             tx_ready,
    input  logic             rx_valid,
    input  logic [7:0]       rx_byte,
    output logic             rsp_valid,
    output logic [7:0]       rsp_data,
    output logic             cmd_done
);

    tx_state_t        state, state_n, nxt;
    cmd_op_t          op_q, op_n;
    logic [6:0]       addr_q, addr_n;
    logic [7:0]       data_q, data_n;
    logic [LEN_W-1:0] len_q, len_n, cnt, cnt_n;
    logic             tx_valid_n, wait_rx, wait_rx_n;
    logic [7:0]       tx_byte_n, rsp_q;
    logic             known, is_read, last_slot, adv;

    // Byte carried by a header slot; read ops put the dummy in their final slot.
    function automatic logic [7:0] slot_byte(tx_state_t st, cmd_op_t op, logic [6:0] addr,
                                             logic [7:0] data, logic [LEN_W-1:0] len);
        logic [7:0] b;
        b = DUMMY_BYTE;
        if (st == ST_ARG0) begin
            case (op)
                OP_DAC_WR: b = data;
                OP_SD_WR:  begin b = {1'b0, addr}; b[SD_WRITE_BIT] = 1'b1; end
                OP_SD_RD:  b = {1'b0, addr};
                OP_STREAM: b = len[7:0];
                default:   b = DUMMY_BYTE;
            endcase
        end else if (st == ST_ARG1) begin
            case (op)
                OP_SD_WR:  b = data;
                OP_STREAM: b = len[15:8];
                default:   b = DUMMY_BYTE;
            endcase
        end
        return b;
    endfunction

    assign known     = op_known(op_q);
    assign is_read   = (op_q == OP_SD_RD) || (op_q == OP_FIFO_RD);
    assign adv       = wait_rx && rx_valid;
    assign last_slot = ((state == ST_ARG0) && (op_q == OP_DAC_WR || op_q == OP_FIFO_RD)) ||
                       ((state == ST_ARG1) && (op_q == OP_SD_WR || op_q == OP_SD_RD)) ||
                       ((state == ST_BODY) && (cnt == len_q));

    assign cmd_ready  = (state == ST_IDLE);
    assign body_ready = (state == ST_BODY) && !tx_valid && !wait_rx;
    assign cmd_done   = (adv && last_slot) || ((state == ST_OPCODE) && !known);
    assign rsp_valid  = adv && last_slot && is_read;
    assign rsp_data   = rsp_valid ? rx_byte : rsp_q;

    always_comb begin
        state_n    = state;
        op_n       = op_q;
        addr_n     = addr_q;
        data_n     = data_q;
        len_n      = len_q;
        cnt_n      = cnt;
        tx_valid_n = tx_valid;
        tx_byte_n  = tx_byte;
        wait_rx_n  = wait_rx;
        case (state)
            ST_OPCODE: nxt = ST_ARG0;
            ST_ARG0:   nxt = ST_ARG1;
            ST_ARG1:   nxt = ST_BODY;
            default:   nxt = state;
        endcase

        case (state)
            ST_IDLE: if (cmd_valid) begin
                op_n       = cmd_op_t'(cmd_op);
                addr_n     = cmd_addr;
                data_n     = cmd_data;
                len_n      = cmd_len;
                cnt_n      = '0;
                state_n    = ST_OPCODE;
                tx_valid_n = op_known(cmd_op_t'(cmd_op));
                tx_byte_n  = op_opcode(cmd_op_t'(cmd_op));
            end
            ST_OPCODE: if (!known) state_n = ST_IDLE;
            default: ;
        endcase

        if (tx_valid && tx_ready) begin
            tx_valid_n = 1'b0;
            wait_rx_n  = 1'b1;
        end

        // rx_valid only counts as the reply once our byte has actually gone out.
        if (adv) begin
            wait_rx_n = 1'b0;
            if (last_slot) begin
                state_n = ST_IDLE;
            end else begin
                state_n = nxt;
                if (state == ST_BODY) cnt_n = cnt + 1'b1;
                if (nxt != ST_BODY) begin
                    tx_valid_n = 1'b1;
                    tx_byte_n  = slot_byte(nxt, op_q, addr_q, data_q, len_q);
                end
            end
        end

        if (body_ready && body_valid) begin
            tx_valid_n = 1'b1;
            tx_byte_n  = body_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= OP_DAC_WR;
            addr_q   <= '0;
            data_q   <= '0;
            len_q    <= '0;
            cnt      <= '0;
            tx_valid <= 1'b0;
            tx_byte  <= '0;
            wait_rx  <= 1'b0;
            rsp_q    <= '0;
        end else begin
            state    <= state_n;
            op_q     <= op_n;
            addr_q   <= addr_n;
            data_q   <= data_n;
            len_q    <= len_n;
            cnt      <= cnt_n;
            tx_valid <= tx_valid_n;
            tx_byte  <= tx_byte_n;
            wait_rx  <= wait_rx_n;
            if (rsp_valid) rsp_q <= rx_byte;
        end
    end

endmodule
